// File: rtl/reg_wb_sched.sv
// Register writeback scheduler: busy scoreboard for issue hazards plus a
// two-requester writeback arbiter feeding the single register-file write port.
// Optional build macro REG_WB_FWD_EN adds write-port forwarding flags.
module reg_wb_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_i,
    input  logic [4:0]  iss_rs1_i,
    input  logic [4:0]  iss_rs2_i,
    output logic        iss_stall_o,
    input  logic        wb0_valid_i,
    input  logic [4:0]  wb0_addr_i,
    input  logic [31:0] wb0_data_i,
    output logic        wb0_ready_o,
    input  logic        wb1_valid_i,
    input  logic [4:0]  wb1_addr_i,
    input  logic [31:0] wb1_data_i,
    output logic        wb1_ready_o,
    output logic        rf_write_en_o,
    output logic [4:0]  rf_write_addr_o,
    output logic [31:0] rf_write_data_o,
    output logic        wb_err_o
`ifdef REG_WB_FWD_EN
    ,
    output logic        fwd_rs1_o,
    output logic        fwd_rs2_o
`endif
);

    // Handshake: a requester holds valid/addr/data stable until it sees ready
    // high in the same cycle; that cycle is the grant and the transfer.
    typedef enum logic {
        PRIO_WB0 = 1'b0,
        PRIO_WB1 = 1'b1
    } prio_e;

    prio_e        prio_q;
    prio_e        prio_d;
    logic [31:1]  busy;
    logic [31:1]  busy_d;
    logic [31:0]  busy_vec;

    logic         rs1_block;
    logic         rs2_block;
    logic         rd_block;
    logic         issue_set;

    logic         grant0;
    logic         grant1;
    logic         grant_any;
    logic [4:0]   grant_addr;
    logic [31:0]  grant_data;
    logic         err_set;

    // x0 reads as never busy through the constant low bit.
    assign busy_vec = {busy, 1'b0};

    always_comb begin
        rs1_block = busy_vec[iss_rs1_i];
        rs2_block = busy_vec[iss_rs2_i];
        rd_block  = busy_vec[iss_rd_i];
`ifdef REG_WB_FWD_EN
        fwd_rs1_o = rf_write_en_o && (rf_write_addr_o == iss_rs1_i) && (iss_rs1_i != 5'd0);
        fwd_rs2_o = rf_write_en_o && (rf_write_addr_o == iss_rs2_i) && (iss_rs2_i != 5'd0);
        // A source being committed this cycle is picked up from the write port.
        if (fwd_rs1_o) rs1_block = 1'b0;
        if (fwd_rs2_o) rs2_block = 1'b0;
`endif
        iss_stall_o = rst_n && iss_valid_i && (rs1_block || rs2_block || rd_block);
        issue_set   = iss_valid_i && !iss_stall_o && (iss_rd_i != 5'd0);
    end

    always_comb begin
        grant0     = rst_n && wb0_valid_i && (!wb1_valid_i || (prio_q == PRIO_WB0));
        grant1     = rst_n && wb1_valid_i && (!wb0_valid_i || (prio_q == PRIO_WB1));
        grant_any  = grant0 || grant1;
        grant_addr = grant1 ? wb1_addr_i : wb0_addr_i;
        grant_data = grant1 ? wb1_data_i : wb0_data_i;
        err_set    = grant_any && (grant_addr != 5'd0) && !busy_vec[grant_addr];
        prio_d     = prio_q;
        if (grant0) begin
            prio_d = PRIO_WB1;
        end else if (grant1) begin
            prio_d = PRIO_WB0;
        end
    end

    assign wb0_ready_o = grant0;
    assign wb1_ready_o = grant1;

    // Clear happens on the commit edge; set and clear never hit the same
    // register because issue stalls on a busy rd.
    always_comb begin
        busy_d = busy;
        for (int i = 1; i < 32; i++) begin
            if (rf_write_en_o && (rf_write_addr_o == 5'(i))) busy_d[i] = 1'b0;
            if (issue_set && (iss_rd_i == 5'(i)))            busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= '0;
            prio_q          <= PRIO_WB0;
            rf_write_en_o   <= 1'b0;
            rf_write_addr_o <= 5'd0;
            rf_write_data_o <= 32'd0;
            wb_err_o        <= 1'b0;
        end else begin
            busy          <= busy_d;
            prio_q        <= prio_d;
            rf_write_en_o <= grant_any && (grant_addr != 5'd0);
            if (grant_any) begin
                rf_write_addr_o <= grant_addr;
                rf_write_data_o <= grant_data;
            end
            wb_err_o <= wb_err_o || err_set;
        end
    end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched: hazard stalls, arbitration order,
// addr-0 writes, error flag and mid-operation reset.
module tb_reg_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        iss_stall;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        wb_err;
`ifdef REG_WB_FWD_EN
    logic        fwd_rs1, fwd_rs2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    reg_wb_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .iss_valid_i     (iss_valid),
        .iss_rd_i        (iss_rd),
        .iss_rs1_i       (iss_rs1),
        .iss_rs2_i       (iss_rs2),
        .iss_stall_o     (iss_stall),
        .wb0_valid_i     (wb0_valid),
        .wb0_addr_i      (wb0_addr),
        .wb0_data_i      (wb0_data),
        .wb0_ready_o     (wb0_ready),
        .wb1_valid_i     (wb1_valid),
        .wb1_addr_i      (wb1_addr),
        .wb1_data_i      (wb1_data),
        .wb1_ready_o     (wb1_ready),
        .rf_write_en_o   (rf_write_en),
        .rf_write_addr_o (rf_write_addr),
        .rf_write_data_o (rf_write_data),
        .wb_err_o        (wb_err)
`ifdef REG_WB_FWD_EN
        ,
        .fwd_rs1_o       (fwd_rs1),
        .fwd_rs2_o       (fwd_rs2)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v;
        iss_rd    = rd;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
    endtask

    task automatic set_wb0(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb0_valid = v;
        wb0_addr  = a;
        wb0_data  = d;
    endtask

    task automatic set_wb1(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb1_valid = v;
        wb1_addr  = a;
        wb1_data  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_wb0(1'b0, 5'd0, 32'd0);
        set_wb1(1'b0, 5'd0, 32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard: every committed write must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && rf_write_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, rf_write_en}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {27'd0, rf_write_addr}, {27'd0, mon_e[36:32]});
                check("wr_data", rf_write_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        do_reset();
        check("rst_en",    {31'd0, rf_write_en}, 32'd0);
        check("rst_addr",  {27'd0, rf_write_addr}, 32'd0);
        check("rst_data",  rf_write_data, 32'd0);
        check("rst_err",   {31'd0, wb_err}, 32'd0);
        check("rst_stall", {31'd0, iss_stall}, 32'd0);

        // RAW hazard on x5, resolved by an ALU writeback.
        set_iss(1'b1, 5'd5, 5'd0, 5'd0);
        #1 check("t1_issue_rd5", {31'd0, iss_stall}, 32'd0);
        step();
        set_iss(1'b1, 5'd0, 5'd5, 5'd0);
        #1 check("t1_raw_stall", {31'd0, iss_stall}, 32'd1);
        set_wb0(1'b1, 5'd5, 32'h0000_DEAD);
        #1 check("t1_wb0_ready", {31'd0, wb0_ready}, 32'd1);
        exp_q.push_back({5'd5, 32'h0000_DEAD});
        step();
        set_wb0(1'b0, 5'd0, 32'd0);
        #1 check("t1_wr_en", {31'd0, rf_write_en}, 32'd1);
`ifdef REG_WB_FWD_EN
        check("t1_stall_fwd", {31'd0, iss_stall}, 32'd0);
        check("t1_fwd_rs1",   {31'd0, fwd_rs1}, 32'd1);
`else
        check("t1_stall_wrcyc", {31'd0, iss_stall}, 32'd1);
`endif
        step();
        check("t1_stall_after", {31'd0, iss_stall}, 32'd0);
        check("t1_wr_en_off",   {31'd0, rf_write_en}, 32'd0);
        check("t1_err",         {31'd0, wb_err}, 32'd0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        step();

        // Contended arbitration after reset: wb0, wb1, wb0, then lone wb1.
        do_reset();
        set_wb0(1'b1, 5'd10, 32'hA000_0010);
        set_wb1(1'b1, 5'd11, 32'hB000_0011);
        #1 check("t2_c1_r0", {31'd0, wb0_ready}, 32'd1);
        check("t2_c1_r1", {31'd0, wb1_ready}, 32'd0);
        exp_q.push_back({5'd10, 32'hA000_0010});
        step();
        set_wb0(1'b1, 5'd12, 32'hA000_0012);
        #1 check("t2_c2_r0", {31'd0, wb0_ready}, 32'd0);
        check("t2_c2_r1", {31'd0, wb1_ready}, 32'd1);
        exp_q.push_back({5'd11, 32'hB000_0011});
        step();
        set_wb1(1'b1, 5'd13, 32'hB000_0013);
        #1 check("t2_c3_r0", {31'd0, wb0_ready}, 32'd1);
        check("t2_c3_r1", {31'd0, wb1_ready}, 32'd0);
        exp_q.push_back({5'd12, 32'hA000_0012});
        step();
        set_wb0(1'b0, 5'd0, 32'd0);
        #1 check("t2_c4_r1", {31'd0, wb1_ready}, 32'd1);
        exp_q.push_back({5'd13, 32'hB000_0013});
        step();
        set_wb1(1'b0, 5'd0, 32'd0);
        step();
        step();

        // Write to x0 is consumed but never reaches the register file.
        do_reset();
        set_wb1(1'b1, 5'd0, 32'h1234_5678);
        #1 check("t3_r1_x0", {31'd0, wb1_ready}, 32'd1);
        step();
        set_wb1(1'b0, 5'd0, 32'd0);
        check("t3_en_x0",  {31'd0, rf_write_en}, 32'd0);
        step();
        check("t3_err_x0", {31'd0, wb_err}, 32'd0);

        // Write to an idle register: performed, error set and sticky.
        set_wb0(1'b1, 5'd7, 32'h0000_0777);
        #1 check("t4_r0", {31'd0, wb0_ready}, 32'd1);
        exp_q.push_back({5'd7, 32'h0000_0777});
        step();
        set_wb0(1'b0, 5'd0, 32'd0);
        check("t4_err_set", {31'd0, wb_err}, 32'd1);
        step();
        step();
        check("t4_err_held", {31'd0, wb_err}, 32'd1);

        // WAW stall on x3, rd=0 never stalls, set+clear of different regs.
        do_reset();
        set_iss(1'b1, 5'd3, 5'd0, 5'd0);
        step();
        #1 check("t5_waw_stall_a", {31'd0, iss_stall}, 32'd1);
        step();
        check("t5_waw_stall_b", {31'd0, iss_stall}, 32'd1);
        set_iss(1'b1, 5'd0, 5'd0, 5'd0);
        #1 check("t5_rd0_nostall", {31'd0, iss_stall}, 32'd0);
        step();
        set_iss(1'b1, 5'd3, 5'd0, 5'd0);
        #1 check("t5_x3_still_busy", {31'd0, iss_stall}, 32'd1);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_wb1(1'b1, 5'd3, 32'h0000_0333);
        #1 check("t5_r1_x3", {31'd0, wb1_ready}, 32'd1);
        exp_q.push_back({5'd3, 32'h0000_0333});
        step();
        set_wb1(1'b0, 5'd0, 32'd0);
        set_iss(1'b1, 5'd4, 5'd0, 5'd0);
        #1 check("t5_issue_rd4", {31'd0, iss_stall}, 32'd0);
        step();
        set_iss(1'b1, 5'd3, 5'd0, 5'd0);
        #1 check("t5_x3_cleared", {31'd0, iss_stall}, 32'd0);
        set_iss(1'b1, 5'd0, 5'd4, 5'd0);
        #1 check("t5_x4_set", {31'd0, iss_stall}, 32'd1);
        check("t5_err", {31'd0, wb_err}, 32'd0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);

        // Reset while x4 is busy and its write sits in the output stage.
        do_reset();
        set_iss(1'b1, 5'd4, 5'd0, 5'd0);
        step();
        set_iss(1'b1, 5'd0, 5'd4, 5'd0);
        set_wb0(1'b1, 5'd4, 32'h0000_0044);
        set_wb1(1'b1, 5'd4, 32'h0000_0055);
        step();
        check("t6_pending_en", {31'd0, rf_write_en}, 32'd1);
        rst_n = 1'b0;
        #1 check("t6_rst_en", {31'd0, rf_write_en}, 32'd0);
        check("t6_rst_addr",  {27'd0, rf_write_addr}, 32'd0);
        check("t6_rst_data",  rf_write_data, 32'd0);
        check("t6_rst_err",   {31'd0, wb_err}, 32'd0);
        check("t6_rst_stall", {31'd0, iss_stall}, 32'd0);
        check("t6_rst_r0",    {31'd0, wb0_ready}, 32'd0);
        check("t6_rst_r1",    {31'd0, wb1_ready}, 32'd0);
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_wb0(1'b0, 5'd0, 32'd0);
        set_wb1(1'b0, 5'd0, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_no_stale_a", {31'd0, rf_write_en}, 32'd0);
        step();
        check("t6_no_stale_b", {31'd0, rf_write_en}, 32'd0);
        set_iss(1'b1, 5'd0, 5'd4, 5'd0);
        #1 check("t6_busy_cleared", {31'd0, iss_stall}, 32'd0);
        set_wb1(1'b1, 5'd0, 32'd0);
        #1 check("t6_ready_follows", {31'd0, wb1_ready}, 32'd1);
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_wb1(1'b0, 5'd0, 32'd0);
        step();
        step();

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wb_sched.md
REG_WB_SCHED -- requirements
Module: reg_wb_sched

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: iss_valid_i  input  1  decode wants to issue an instruction this cycle.
REQ-004 SHALL have ports: iss_rd_i, iss_rs1_i, iss_rs2_i  input  5 each  destination and source register numbers of the issuing instruction.
REQ-005 SHALL have ports: iss_stall_o  output  1  issue blocked by a register hazard this cycle.
REQ-006 SHALL have ports: wb0_valid_i  input  1; wb0_addr_i  input  5; wb0_data_i  input  32  ALU writeback request.
REQ-007 SHALL have ports: wb0_ready_o  output  1  ALU writeback accepted this cycle.
REQ-008 SHALL have ports: wb1_valid_i  input  1; wb1_addr_i  input  5; wb1_data_i  input  32  load/store writeback request.
REQ-009 SHALL have ports: wb1_ready_o  output  1  load/store writeback accepted this cycle.
REQ-010 SHALL have ports: rf_write_en_o  output  1; rf_write_addr_o  output  5; rf_write_data_o  output  32  register file single write port.
REQ-011 SHALL have ports: wb_err_o  output  1  sticky writeback-to-idle-register error.

Function
REQ-012 SHALL hold busy[31:1], one bit per GP register; x0 never busy.
REQ-013 SHALL assert iss_stall_o combinationally when iss_valid_i=1 and busy is set for any of rs1, rs2 or rd (RAW and WAW).
REQ-014 SHALL set busy[rd] on the clock edge where iss_valid_i=1, iss_stall_o=0 and rd!=0.
REQ-015 SHALL require requesters to hold valid, addr and data stable until ready; ready SHALL be combinational from valids and the priority flag.
REQ-016 SHALL grant at most one requester per cycle; an uncontended valid is granted immediately.
REQ-017 SHALL on contention grant the requester named by the priority flag; after any grant, the flag SHALL point to the other requester.
REQ-018 SHALL register the granted addr and data into the output stage: grant in cycle N -> rf_write_* presented in cycle N+1, with rf_write_en_o high for exactly one cycle per grant.
REQ-019 SHALL consume a granted write to addr 0 (ready=1) but keep rf_write_en_o=0 for it.
REQ-020 SHALL clear busy[rf_write_addr_o] on the edge ending a cycle with rf_write_en_o=1, i.e. the same edge the register file commits.
REQ-021 SHALL, when set and clear target different registers on one edge, apply both.
REQ-022 SHALL never see set and clear on the same register on one edge, because rule REQ-013 blocks issue to a busy rd.
REQ-023 SHALL set wb_err_o on a grant whose addr!=0 and whose busy bit is clear; the write SHALL still be performed; wb_err_o SHALL stay set until reset.

Reset
REQ-024 SHALL on rst_n=0, asynchronously: busy=0, rf_write_en_o=0, rf_write_addr_o=0, rf_write_data_o=0, priority flag -> wb0, wb_err_o=0.
REQ-025 SHALL, on reset mid-operation, discard pending and in-flight writes; ready outputs SHALL follow the valid inputs from the first cycle after deassertion.

Configuration
REQ-026 SHALL support macro REG_WB_FWD_EN.
REQ-027 SHALL, when REG_WB_FWD_EN is defined, add outputs fwd_rs1_o and fwd_rs2_o (1 bit each).
REQ-028 SHALL drive fwd_rsN_o high when rf_write_en_o=1 and rf_write_addr_o equals rsN (rsN!=0); a forwarded source SHALL NOT cause a stall, and decode SHALL take rf_write_data_o for it.
REQ-029 SHALL, when REG_WB_FWD_EN is undefined, omit the fwd ports and stall on every busy source until its busy bit clears.

Verification
REQ-030 SHALL cover: issue rd=5, then issue rs1=5 -> stall; wb0 x5=0xDEAD -> rf_write next cycle; stall drops the cycle after the commit, or during the write cycle with fwd_rs1_o=1 when REG_WB_FWD_EN is defined.
REQ-031 SHALL cover: wb0 and wb1 valid together for 3 cycles after reset -> grants wb0, wb1, wb0; rf_write addresses follow the same order.
REQ-032 SHALL cover: wb1 to addr 0 -> wb1_ready_o=1, rf_write_en_o stays 0, wb_err_o stays 0.
REQ-033 SHALL cover: wb0 to x7 with busy[7]=0 -> x7 written, wb_err_o=1 and held.
REQ-034 SHALL cover: issue rd=3 held stalled while x3 busy; issue rd=0 -> never stalls on rd, busy unchanged.
REQ-035 SHALL cover: assert rst_n=0 while busy=0x0000_0010 and an output write is pending -> all outputs 0 immediately; no stale write after release.
